// File: rtl/cam_rx_word_aligner_pkg.sv
// Shared types and defaults for the camera deserializer word aligner.
// Holds the FSM encoding, default training words and counter widths.
package cam_rx_word_aligner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CHECK  = 3'd2,
    ST_SLIP   = 3'd3,
    ST_NEXT   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam int LANE_W = 3;
  localparam int CNT_W  = 8;

  localparam logic [7:0] TRAIN_D_DEF = 8'h3A;
  localparam logic [7:0] TRAIN_S_DEF = 8'hE9;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cam_rx_word_aligner_lane_mux.sv
// Registered lane selector: presents the chosen lane's word and the
// training word it should carry, one cycle after the lane index.
module cam_rx_word_aligner_lane_mux
  import cam_rx_word_aligner_pkg::*;
#(
  parameter int         NCH     = 5,
  parameter int         W       = 8,
  parameter logic [W-1:0] TRAIN_D = TRAIN_D_DEF,
  parameter logic [W-1:0] TRAIN_S = TRAIN_S_DEF
) (
  input  logic              c,
  input  logic              r,
  input  logic [LANE_W-1:0] lane_i,
  input  logic [NCH*W-1:0]  rxd_i,
  output logic [W-1:0]      word_o,
  output logic [W-1:0]      train_o
);

  logic [W-1:0] lane_word [NCH];
  logic [W-1:0] word_d, word_q;
  logic [W-1:0] train_d, train_q;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_lane
      assign lane_word[gi] = rxd_i[gi*W +: W];
    end
  endgenerate

  always_comb begin
    word_d = '0;
    for (int k = 0; k < NCH; k++) begin
      if (lane_i == LANE_W'(k)) word_d = lane_word[k];
    end
    train_d = (lane_i == LANE_W'(NCH-1)) ? TRAIN_S : TRAIN_D;
  end

  always_ff @(posedge c) begin
    if (r) begin
      word_q  <= '0;
      train_q <= '0;
    end else begin
      word_q  <= word_d;
      train_q <= train_d;
    end
  end

  assign word_o  = word_q;
  assign train_o = train_q;

endmodule

// File: rtl/cam_rx_word_aligner.sv
// Per-camera word-alignment controller: walks each deserializer lane,
// bitslipping it until its training word repeats MATCH_CNT times.
module cam_rx_word_aligner
  import cam_rx_word_aligner_pkg::*;
#(
  parameter int           NCH       = 5,
  parameter int           W         = 8,
  parameter logic [W-1:0] TRAIN_D   = TRAIN_D_DEF,
  parameter logic [W-1:0] TRAIN_S   = TRAIN_S_DEF,
  parameter int           SETTLE    = 4,
  parameter int           MATCH_CNT = 16,
  parameter int           MAX_SLIP  = 16
) (
  input  logic             c,
  input  logic             r,
  input  logic             rx_locked,
  input  logic             retrain,
  input  logic [NCH*W-1:0] rxd,
  output logic [NCH-1:0]   rxd_align,
  output logic             busy,
  output logic             done,
  output logic             aligned,
  output logic [NCH-1:0]   fail_mask,
  output logic [2:0]       cur_lane,
  output logic [7:0]       slip_total
);

  state_e              state_q, state_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [CNT_W-1:0]    settle_q, settle_d;
  logic [CNT_W-1:0]    match_q, match_d;
  logic [CNT_W-1:0]    slip_q, slip_d;
  logic [7:0]          total_q, total_d;
  logic [NCH-1:0]      fail_q, fail_d;
  logic [NCH-1:0]      align_q, align_d;
  logic                done_q, done_d;
  logic                aligned_q, aligned_d;
  logic [W-1:0]        sel_word, sel_train;

  cam_rx_word_aligner_lane_mux #(
    .NCH(NCH), .W(W), .TRAIN_D(TRAIN_D), .TRAIN_S(TRAIN_S)
  ) u_lane_mux (
    .c       (c),
    .r       (r),
    .lane_i  (lane_q),
    .rxd_i   (rxd),
    .word_o  (sel_word),
    .train_o (sel_train)
  );

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    settle_d  = settle_q;
    match_d   = match_q;
    slip_d    = slip_q;
    total_d   = total_q;
    fail_d    = fail_q;
    align_d   = '0;
    done_d    = done_q;
    aligned_d = aligned_q;

    // Lock loss beats retrain; fail_mask and slip_total are kept for readout.
    if (!rx_locked) begin
      state_d   = ST_IDLE;
      done_d    = 1'b0;
      aligned_d = 1'b0;
    end else if (state_q == ST_IDLE || retrain) begin
      state_d   = ST_SETTLE;
      lane_d    = '0;
      settle_d  = '0;
      match_d   = '0;
      slip_d    = '0;
      total_d   = '0;
      fail_d    = '0;
      done_d    = 1'b0;
      aligned_d = 1'b0;
    end else begin
      case (state_q)
        ST_SETTLE: begin
          if (settle_q == CNT_W'(SETTLE-1)) state_d = ST_CHECK;
          else                              settle_d = settle_q + 1'b1;
        end
        ST_CHECK: begin
          if (sel_word == sel_train) begin
            match_d = match_q + 1'b1;
            if (match_q == CNT_W'(MATCH_CNT-1)) state_d = ST_NEXT;
          end else begin
            state_d = ST_SLIP;
          end
        end
        ST_SLIP: begin
          if (slip_q >= CNT_W'(MAX_SLIP)) begin
            fail_d[lane_q] = 1'b1;
            state_d        = ST_NEXT;
          end else begin
            align_d[lane_q] = 1'b1;
            slip_d          = slip_q + 1'b1;
            total_d         = sat_inc(total_q);
            settle_d        = '0;
            match_d         = '0;
            state_d         = ST_SETTLE;
          end
        end
        ST_NEXT: begin
          if (lane_q == LANE_W'(NCH-1)) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            aligned_d = ~|fail_q;
          end else begin
            lane_d   = lane_q + 1'b1;
            slip_d   = '0;
            settle_d = '0;
            match_d  = '0;
            state_d  = ST_SETTLE;
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge c) begin
    if (r) begin
      state_q   <= ST_IDLE;
      lane_q    <= '0;
      settle_q  <= '0;
      match_q   <= '0;
      slip_q    <= '0;
      total_q   <= '0;
      fail_q    <= '0;
      align_q   <= '0;
      done_q    <= 1'b0;
      aligned_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      settle_q  <= settle_d;
      match_q   <= match_d;
      slip_q    <= slip_d;
      total_q   <= total_d;
      fail_q    <= fail_d;
      align_q   <= align_d;
      done_q    <= done_d;
      aligned_q <= aligned_d;
    end
  end

  assign rxd_align  = align_q;
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done       = done_q;
  assign aligned    = aligned_q;
  assign fail_mask  = fail_q;
  assign cur_lane   = lane_q;
  assign slip_total = total_q;

endmodule

// File: tb/tb_cam_rx_word_aligner.sv
// Bench for the word aligner: a bit-rotating deserializer model feeds the
// lanes, and outcomes are predicted from each lane's initial bit rotation.
module tb_cam_rx_word_aligner;

  localparam int NCH       = 5;
  localparam int W         = 8;
  localparam int SETTLE    = 4;
  localparam int MATCH_CNT = 16;
  localparam int MAX_SLIP  = 16;
  localparam logic [7:0] TRAIN_D = 8'h3A;
  localparam logic [7:0] TRAIN_S = 8'hE9;
  localparam int WORST = NCH*(MAX_SLIP*(SETTLE+2)+SETTLE+MATCH_CNT+2);

  logic             c = 1'b0;
  logic             r;
  logic             rx_locked;
  logic             retrain;
  logic [NCH*W-1:0] rxd;
  logic [NCH-1:0]   rxd_align;
  logic             busy, done, aligned;
  logic [NCH-1:0]   fail_mask;
  logic [2:0]       cur_lane;
  logic [7:0]       slip_total;

  cam_rx_word_aligner dut (
    .c(c), .r(r), .rx_locked(rx_locked), .retrain(retrain), .rxd(rxd),
    .rxd_align(rxd_align), .busy(busy), .done(done), .aligned(aligned),
    .fail_mask(fail_mask), .cur_lane(cur_lane), .slip_total(slip_total)
  );

  always #5 c = ~c;

  int total = 0;
  int bad   = 0;

  // Deserializer model: each lane shows its training word rotated left by rot[k].
  int   rot[NCH] = '{default: 0};
  bit   sync_zero = 0;
  bit   freeze0   = 0;
  bit   glitch0   = 0;
  logic [7:0] lane_w;

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [7:0] y;
    y = x;
    for (int i = 0; i < n; i++) y = {y[6:0], y[7]};
    return y;
  endfunction

  always_comb begin
    rxd    = '0;
    lane_w = '0;
    for (int k = 0; k < NCH; k++) begin
      lane_w = rotl8((k == NCH-1) ? TRAIN_S : TRAIN_D, rot[k]);
      if (k == NCH-1 && sync_zero) lane_w = 8'h00;
      if (k == 0 && glitch0)       lane_w = 8'h00;
      rxd[k*W +: W] = lane_w;
    end
  end

  // Pulse monitor: counts slips per lane and flags shape/spacing violations.
  bit             mon_en = 0;
  int             cyc = 0;
  int             last_pulse = -100;
  int             viol = 0;
  int             pulses[NCH] = '{default: 0};
  logic [NCH-1:0] prev_align = '0;

  always @(negedge c) begin
    cyc = cyc + 1;
    if (mon_en) begin
      if (rxd_align !== '0) begin
        if (!$onehot(rxd_align)) viol = viol + 1;
        if (prev_align !== '0) viol = viol + 1;
        if (cyc - last_pulse < SETTLE + 1) viol = viol + 1;
        last_pulse = cyc;
        for (int k = 0; k < NCH; k++) begin
          if (rxd_align[k] === 1'b1) begin
            pulses[k] = pulses[k] + 1;
            if (!(k == 0 && freeze0)) rot[k] = (rot[k] + 7) % 8;
          end
        end
      end
      prev_align = rxd_align;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge c);
  endtask

  task automatic start_run(input int r0, input int r1, input int r2, input int r3, input int r4);
    @(negedge c);
    rx_locked = 1'b0;
    retrain   = 1'b0;
    rot[0] = r0; rot[1] = r1; rot[2] = r2; rot[3] = r3; rot[4] = r4;
    @(negedge c);
    rx_locked = 1'b1;
  endtask

  task automatic wait_done(input int limit, output int cycles, output bit ok);
    cycles = 0;
    ok = 0;
    while (cycles < limit && !ok) begin
      @(negedge c);
      cycles++;
      if (done === 1'b1) ok = 1;
    end
  endtask

  task automatic test_reset;
    r = 1'b1; rx_locked = 1'b1; retrain = 1'b1;
    tick(3);
    total++;
    if ({rxd_align, busy, done, aligned, fail_mask, cur_lane, slip_total} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got align=%b busy=%b done=%b aligned=%b fail=%b lane=%0d slips=%0d want all 0",
               rxd_align, busy, done, aligned, fail_mask, cur_lane, slip_total);
    end
    r = 1'b0; rx_locked = 1'b0; retrain = 1'b1;
    tick(1);
    retrain = 1'b0;
    tick(1);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL idle_retrain_ignored: busy got %b want 0", busy);
    end
    mon_en = 1;
  endtask

  task automatic test_in_phase;
    int p0[NCH]; int cycles; bit ok; int d;
    p0 = pulses;
    start_run(0, 0, 0, 0, 0);
    wait_done(NCH*(SETTLE+MATCH_CNT+2)+2, cycles, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL t1_done_time: no done after %0d cycles want <=112", cycles); end
    total++;
    if (aligned !== 1'b1) begin bad++; $display("FAIL t1_aligned: got %b want 1", aligned); end
    total++;
    if (slip_total !== 8'd0) begin bad++; $display("FAIL t1_slip_total: got %0d want 0", slip_total); end
    d = 0;
    for (int k = 0; k < NCH; k++) d += pulses[k] - p0[k];
    total++;
    if (d !== 0) begin bad++; $display("FAIL t1_pulses: got %0d want 0", d); end
  endtask

  task automatic test_lane_slip;
    int p0[NCH]; int v0; int cycles; bit ok;
    p0 = pulses; v0 = viol;
    start_run(0, 0, 3, 0, 0);
    wait_done(WORST + 4, cycles, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL t2_done: timeout after %0d cycles", cycles); end
    for (int k = 0; k < NCH; k++) begin
      total++;
      if (pulses[k] - p0[k] !== ((k == 2) ? 3 : 0)) begin
        bad++; $display("FAIL t2_lane%0d_pulses: got %0d want %0d", k, pulses[k] - p0[k], (k == 2) ? 3 : 0);
      end
    end
    total++;
    if (slip_total !== 8'd3 || aligned !== 1'b1) begin
      bad++; $display("FAIL t2_status: got slips=%0d aligned=%b want 3/1", slip_total, aligned);
    end
    total++;
    if (viol - v0 !== 0) begin bad++; $display("FAIL t2_pulse_shape: got %0d violations want 0", viol - v0); end
  endtask

  task automatic test_sync_fail;
    int p0[NCH]; int cycles; bit ok;
    p0 = pulses;
    sync_zero = 1;
    start_run(0, 0, 0, 0, 0);
    wait_done(WORST + 4, cycles, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL t3_done: timeout after %0d cycles", cycles); end
    total++;
    if (pulses[NCH-1] - p0[NCH-1] !== MAX_SLIP) begin
      bad++; $display("FAIL t3_sync_pulses: got %0d want %0d", pulses[NCH-1] - p0[NCH-1], MAX_SLIP);
    end
    total++;
    if (fail_mask !== 5'b10000 || aligned !== 1'b0 || done !== 1'b1) begin
      bad++; $display("FAIL t3_status: got fail=%b aligned=%b done=%b want 10000/0/1", fail_mask, aligned, done);
    end
    total++;
    if (slip_total !== 8'(MAX_SLIP)) begin bad++; $display("FAIL t3_slip_total: got %0d want %0d", slip_total, MAX_SLIP); end
    rx_locked = 1'b0;
    tick(1);
    total++;
    if (done !== 1'b0 || aligned !== 1'b0 || busy !== 1'b0 || fail_mask !== 5'b10000 || slip_total !== 8'(MAX_SLIP)) begin
      bad++; $display("FAIL t3_post_mortem: got done=%b aligned=%b busy=%b fail=%b slips=%0d want 0/0/0/10000/16",
                      done, aligned, busy, fail_mask, slip_total);
    end
    sync_zero = 0;
  endtask

  task automatic test_lock_loss;
    int cycles; bit ok; bit seen; int remaining;
    start_run(0, 5, 0, 0, 0);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge c);
      if (rxd_align[1] === 1'b1) seen = 1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL t4_first_pulse: got none want lane1 pulse"); end
    // Next slip decision on lane 1 falls SETTLE+1 cycles after this pulse.
    tick(SETTLE + 1);
    rx_locked = 1'b0;
    tick(1);
    total++;
    if (rxd_align !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL t4_lock_drop: got align=%b busy=%b done=%b want 0/0/0", rxd_align, busy, done);
    end
    total++;
    if (slip_total !== 8'd1 || fail_mask !== '0) begin
      bad++; $display("FAIL t4_hold: got slips=%0d fail=%b want 1/00000", slip_total, fail_mask);
    end
    remaining = rot[1];
    rx_locked = 1'b1;
    tick(1);
    total++;
    if (busy !== 1'b1 || cur_lane !== 3'd0 || slip_total !== 8'd0 || fail_mask !== '0) begin
      bad++; $display("FAIL t4_relock: got busy=%b lane=%0d slips=%0d fail=%b want 1/0/0/0", busy, cur_lane, slip_total, fail_mask);
    end
    wait_done(WORST + 4, cycles, ok);
    total++;
    if (!ok || slip_total !== 8'(remaining) || aligned !== 1'b1) begin
      bad++; $display("FAIL t4_finish: got done=%b slips=%0d aligned=%b want 1/%0d/1", ok, slip_total, aligned, remaining);
    end
  endtask

  task automatic test_retrain;
    int cycles; bit ok;
    @(negedge c);
    retrain = 1'b1;
    tick(1);
    retrain = 1'b0;
    total++;
    if (busy !== 1'b1 || cur_lane !== 3'd0 || done !== 1'b0) begin
      bad++; $display("FAIL t5_retrain_done: got busy=%b lane=%0d done=%b want 1/0/0", busy, cur_lane, done);
    end
    wait_done(WORST + 4, cycles, ok);
    total++;
    if (!ok || aligned !== 1'b1 || cur_lane !== 3'(NCH-1)) begin
      bad++; $display("FAIL t5_rerun: got done=%b aligned=%b lane=%0d want 1/1/4", ok, aligned, cur_lane);
    end
    retrain = 1'b1; rx_locked = 1'b0;
    tick(1);
    retrain = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL t5_retrain_vs_lock: got busy=%b done=%b want 0/0", busy, done);
    end
    tick(3);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL t5_stay_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_glitch;
    int p0[NCH]; int cycles; bit ok; bit seen; int t_pulse; int gap;
    p0 = pulses;
    freeze0 = 1;
    start_run(0, 0, 0, 0, 0);
    // One bad word lands on the 16th compare of lane 0.
    repeat (19) @(posedge c);
    @(negedge c);
    glitch0 = 1;
    @(negedge c);
    glitch0 = 0;
    seen = 0; t_pulse = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge c);
      if (rxd_align[0] === 1'b1) begin seen = 1; t_pulse = cyc; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL t6_slip: got no lane0 pulse want 1"); end
    seen = 0; gap = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge c);
      if (cur_lane === 3'd1) begin seen = 1; gap = cyc - t_pulse; end
    end
    total++;
    if (!seen || gap < SETTLE + MATCH_CNT) begin
      bad++; $display("FAIL t6_match_restart: got %0d cycles to lane 1 want >=%0d", gap, SETTLE + MATCH_CNT);
    end
    wait_done(WORST + 4, cycles, ok);
    total++;
    if (!ok || pulses[0] - p0[0] !== 1 || slip_total !== 8'd1 || aligned !== 1'b1) begin
      bad++; $display("FAIL t6_result: got done=%b lane0_pulses=%0d slips=%0d aligned=%b want 1/1/1/1",
                      ok, pulses[0] - p0[0], slip_total, aligned);
    end
    freeze0 = 0;
  endtask

  task automatic test_random;
    int rr[NCH]; int p0[NCH]; int cycles; bit ok; int sum;
    for (int it = 0; it < 4; it++) begin
      sum = 0;
      for (int k = 0; k < NCH; k++) begin
        rr[k] = int'($urandom_range(7));
        sum += rr[k];
      end
      p0 = pulses;
      start_run(rr[0], rr[1], rr[2], rr[3], rr[4]);
      wait_done(WORST + 4, cycles, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rnd%0d_done: timeout after %0d cycles", it, cycles); end
      for (int k = 0; k < NCH; k++) begin
        total++;
        if (pulses[k] - p0[k] !== rr[k]) begin
          bad++; $display("FAIL rnd%0d_lane%0d_pulses: got %0d want %0d", it, k, pulses[k] - p0[k], rr[k]);
        end
      end
      total++;
      if (slip_total !== 8'(sum) || aligned !== 1'b1 || fail_mask !== '0) begin
        bad++; $display("FAIL rnd%0d_status: got slips=%0d aligned=%b fail=%b want %0d/1/00000",
                        it, slip_total, aligned, fail_mask, sum);
      end
    end
    total++;
    if (viol !== 0) begin bad++; $display("FAIL pulse_rules: got %0d violations want 0", viol); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    r = 1'b1; rx_locked = 1'b0; retrain = 1'b0;
    test_reset;
    test_in_phase;
    test_lane_slip;
    test_sync_fail;
    test_lock_loss;
    test_retrain;
    test_glitch;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
